// File: rtl/pipe_id_control.sv
// ID-stage control unit for the five-stage MIPS pipeline: decode, next-PC select,
// forwarding selects and load-use stall. Optional stall counter under PIPEIDCU_STALL_CNT_EN.
module pipe_id_control (
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       rsrtequ,
    input  logic       ewreg,
    input  logic       em2reg,
    input  logic [4:0] ern,
    input  logic       mwreg,
    input  logic [4:0] mrn,
    output logic       wreg,
    output logic       m2reg,
    output logic       wmem,
    output logic [4:0] aluc,
    output logic       regrt,
    output logic       aluimm,
    output logic       sext,
    output logic [1:0] pcsource,
    output logic       shift,
    output logic       jal,
    output logic       load_depen,
    output logic [1:0] a_depen,
    output logic [1:0] b_depen
`ifdef PIPEIDCU_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_LUI  = 5'b00101;
    localparam logic [4:0] ALU_SLL  = 5'b00110;
    localparam logic [4:0] ALU_SRL  = 5'b00111;
    localparam logic [4:0] ALU_SRA  = 5'b01000;
    localparam logic [4:0] ALU_SLT  = 5'b01001;
    localparam logic [4:0] ALU_NOR  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;

    logic rdy;
    logic dec_wreg;
    logic dec_wmem;
    logic uses_rs;
    logic uses_rt;

    // Holds register writes off until the first clock edge after reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rdy <= 1'b0;
        end else begin
            rdy <= 1'b1;
        end
    end

    always_comb begin
        dec_wreg = 1'b0;
        dec_wmem = 1'b0;
        m2reg    = 1'b0;
        aluc     = ALU_ADD;
        regrt    = 1'b0;
        aluimm   = 1'b0;
        sext     = 1'b0;
        pcsource = 2'b00;
        shift    = 1'b0;
        jal      = 1'b0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  begin dec_wreg = 1'b1; aluc = ALU_ADD;  uses_rs = 1'b1; uses_rt = 1'b1; end
                    FN_SUB:  begin dec_wreg = 1'b1; aluc = ALU_SUB;  uses_rs = 1'b1; uses_rt = 1'b1; end
                    FN_AND:  begin dec_wreg = 1'b1; aluc = ALU_AND;  uses_rs = 1'b1; uses_rt = 1'b1; end
                    FN_OR:   begin dec_wreg = 1'b1; aluc = ALU_OR;   uses_rs = 1'b1; uses_rt = 1'b1; end
                    FN_XOR:  begin dec_wreg = 1'b1; aluc = ALU_XOR;  uses_rs = 1'b1; uses_rt = 1'b1; end
                    FN_NOR:  begin dec_wreg = 1'b1; aluc = ALU_NOR;  uses_rs = 1'b1; uses_rt = 1'b1; end
                    FN_SLT:  begin dec_wreg = 1'b1; aluc = ALU_SLT;  uses_rs = 1'b1; uses_rt = 1'b1; end
                    FN_SLTU: begin dec_wreg = 1'b1; aluc = ALU_SLTU; uses_rs = 1'b1; uses_rt = 1'b1; end
                    // Shifts take their A operand from sa, so rs is not read.
                    FN_SLL:  begin dec_wreg = 1'b1; shift = 1'b1; aluc = ALU_SLL; uses_rt = 1'b1; end
                    FN_SRL:  begin dec_wreg = 1'b1; shift = 1'b1; aluc = ALU_SRL; uses_rt = 1'b1; end
                    FN_SRA:  begin dec_wreg = 1'b1; shift = 1'b1; aluc = ALU_SRA; uses_rt = 1'b1; end
                    FN_JR:   begin pcsource = 2'b10; uses_rs = 1'b1; uses_rt = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b1;
                aluc = ALU_ADD; uses_rs = 1'b1;
            end
            OP_SLTI: begin
                dec_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b1;
                aluc = ALU_SLT; uses_rs = 1'b1;
            end
            OP_ANDI: begin
                dec_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1;
                aluc = ALU_AND; uses_rs = 1'b1;
            end
            OP_ORI: begin
                dec_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1;
                aluc = ALU_OR; uses_rs = 1'b1;
            end
            OP_XORI: begin
                dec_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1;
                aluc = ALU_XOR; uses_rs = 1'b1;
            end
            OP_LUI: begin
                dec_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1;
                aluc = ALU_LUI;
            end
            OP_LW: begin
                dec_wreg = 1'b1; regrt = 1'b1; aluimm = 1'b1; sext = 1'b1; m2reg = 1'b1;
                uses_rs = 1'b1;
            end
            OP_SW: begin
                dec_wmem = 1'b1; aluimm = 1'b1; sext = 1'b1;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_BEQ: begin
                sext = 1'b1; aluc = ALU_SUB;
                pcsource = rsrtequ ? 2'b01 : 2'b00;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_BNE: begin
                sext = 1'b1; aluc = ALU_SUB;
                pcsource = rsrtequ ? 2'b00 : 2'b01;
                uses_rs = 1'b1; uses_rt = 1'b1;
            end
            OP_J: begin
                pcsource = 2'b11;
            end
            OP_JAL: begin
                pcsource = 2'b11; jal = 1'b1; dec_wreg = 1'b1;
            end
            default: ;
        endcase
    end

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;

    // A load in EX cannot forward; it only ever shows up as load_depen.
    assign ex_hit_rs  = ewreg & (ern != 5'd0) & (ern == rs) & ~em2reg;
    assign ex_hit_rt  = ewreg & (ern != 5'd0) & (ern == rt) & ~em2reg;
    assign mem_hit_rs = mwreg & (mrn != 5'd0) & (mrn == rs);
    assign mem_hit_rt = mwreg & (mrn != 5'd0) & (mrn == rt);

    assign a_depen = ex_hit_rs ? 2'b01 : (mem_hit_rs ? 2'b10 : 2'b00);
    assign b_depen = ex_hit_rt ? 2'b01 : (mem_hit_rt ? 2'b10 : 2'b00);

    assign load_depen = ewreg & em2reg & (ern != 5'd0) &
                        (((ern == rs) & uses_rs) | ((ern == rt) & uses_rt));

    // Bubble: suppress architectural writes while stalled or before rdy.
    assign wreg = dec_wreg & rdy & ~load_depen;
    assign wmem = dec_wmem & rdy & ~load_depen;

`ifdef PIPEIDCU_STALL_CNT_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            stall_cnt <= 16'd0;
        end else if (load_depen && rdy && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_id_control.sv
// Randomized bench for pipe_id_control against a table-driven instruction model.
module tb_pipe_id_control;

    logic       clk = 1'b0;
    logic       clrn;
    logic [5:0] op, func;
    logic [4:0] rs, rt, ern, mrn;
    logic       rsrtequ, ewreg, em2reg, mwreg;
    logic       wreg, m2reg, wmem, regrt, aluimm, sext, shift, jal, load_depen;
    logic [4:0] aluc;
    logic [1:0] pcsource, a_depen, b_depen;
`ifdef PIPEIDCU_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_id_control dut (
        .clk(clk), .clrn(clrn), .op(op), .func(func), .rs(rs), .rt(rt),
        .rsrtequ(rsrtequ), .ewreg(ewreg), .em2reg(em2reg), .ern(ern),
        .mwreg(mwreg), .mrn(mrn), .wreg(wreg), .m2reg(m2reg), .wmem(wmem),
        .aluc(aluc), .regrt(regrt), .aluimm(aluimm), .sext(sext),
        .pcsource(pcsource), .shift(shift), .jal(jal), .load_depen(load_depen),
        .a_depen(a_depen), .b_depen(b_depen)
`ifdef PIPEIDCU_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Instruction table: flags = {wreg,m2reg,wmem,regrt,aluimm,sext,shift,jal}
    // pc_kind: 0 none, 1 beq, 2 bne, 3 jr, 4 jump
    typedef struct {
        logic       is_r;
        logic [5:0] code;
        logic [4:0] aluc;
        logic [7:0] flags;
        int         pc_kind;
        logic       urs;
        logic       urt;
    } ins_t;

    ins_t tbl[$];

    task automatic add_ins(input logic is_r, input logic [5:0] code, input logic [4:0] a,
                           input logic [7:0] f, input int pk, input logic urs, input logic urt);
        ins_t e;
        e.is_r = is_r; e.code = code; e.aluc = a; e.flags = f;
        e.pc_kind = pk; e.urs = urs; e.urt = urt;
        tbl.push_back(e);
    endtask

    task automatic build_table();
        add_ins(1, 6'h20, 5'h00, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h22, 5'h01, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h24, 5'h02, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h25, 5'h03, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h26, 5'h04, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h27, 5'h0A, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h2A, 5'h09, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h2B, 5'h0B, 8'b1000_0000, 0, 1, 1);
        add_ins(1, 6'h00, 5'h06, 8'b1000_0010, 0, 0, 1);
        add_ins(1, 6'h02, 5'h07, 8'b1000_0010, 0, 0, 1);
        add_ins(1, 6'h03, 5'h08, 8'b1000_0010, 0, 0, 1);
        add_ins(1, 6'h08, 5'h00, 8'b0000_0000, 3, 1, 1);
        add_ins(0, 6'h08, 5'h00, 8'b1001_1100, 0, 1, 0);
        add_ins(0, 6'h0A, 5'h09, 8'b1001_1100, 0, 1, 0);
        add_ins(0, 6'h0C, 5'h02, 8'b1001_1000, 0, 1, 0);
        add_ins(0, 6'h0D, 5'h03, 8'b1001_1000, 0, 1, 0);
        add_ins(0, 6'h0E, 5'h04, 8'b1001_1000, 0, 1, 0);
        add_ins(0, 6'h0F, 5'h05, 8'b1001_1000, 0, 0, 0);
        add_ins(0, 6'h23, 5'h00, 8'b1101_1100, 0, 1, 0);
        add_ins(0, 6'h2B, 5'h00, 8'b0010_1100, 0, 1, 1);
        add_ins(0, 6'h04, 5'h01, 8'b0000_0100, 1, 1, 1);
        add_ins(0, 6'h05, 5'h01, 8'b0000_0100, 2, 1, 1);
        add_ins(0, 6'h02, 5'h00, 8'b0000_0000, 4, 0, 0);
        add_ins(0, 6'h03, 5'h00, 8'b1000_0001, 4, 0, 0);
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] r);
        if (ewreg && ern != 0 && ern == r && !em2reg) return 2'd1;
        if (mwreg && mrn != 0 && mrn == r) return 2'd2;
        return 2'd0;
    endfunction

    // Expected {ctrl(15), hazard(5)} for an entry, given current inputs and rdy.
    task automatic model(input ins_t e, input logic rdy_m, output logic [14:0] ctrl,
                         output logic [4:0] haz);
        logic ld;
        logic [1:0] pc;
        ld = ewreg && em2reg && ern != 0 &&
             ((ern == rs && e.urs) || (ern == rt && e.urt));
        case (e.pc_kind)
            1: pc = rsrtequ ? 2'd1 : 2'd0;
            2: pc = rsrtequ ? 2'd0 : 2'd1;
            3: pc = 2'd2;
            4: pc = 2'd3;
            default: pc = 2'd0;
        endcase
        ctrl = {e.flags[7] & rdy_m & ~ld, e.flags[6], e.flags[5] & rdy_m & ~ld, e.aluc,
                e.flags[4], e.flags[3], e.flags[2], pc, e.flags[1], e.flags[0]};
        haz = {ld, fwd(rs), fwd(rt)};
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                         input logic [4:0] t, input logic eq, input logic ew, input logic em,
                         input logic [4:0] en, input logic mw, input logic [4:0] mn);
        op = o; func = f; rs = s; rt = t; rsrtequ = eq;
        ewreg = ew; em2reg = em; ern = en; mwreg = mw; mrn = mn;
    endtask

    function automatic logic [14:0] ctrl_vec();
        return {wreg, m2reg, wmem, aluc, regrt, aluimm, sext, pcsource, shift, jal};
    endfunction

    initial begin
        logic [14:0] ec;
        logic [4:0]  eh;
        int idx;
        ins_t e;
        build_table();

        clrn = 1'b0;
        drive(6'h2B, 6'h00, 5'd2, 5'd3, 0, 0, 0, 5'd0, 0, 5'd0);
        #2;
        check("reset_sw_wmem", wmem, 0);
        check("reset_sw_aluimm", aluimm, 1);
        check("reset_sw_sext", sext, 1);
        #5 clrn = 1'b1;
        #2;
        check("pre_edge_wmem", wmem, 0);
        @(posedge clk); #2;
        check("post_edge_wmem", wmem, 1);
        check("post_edge_aluimm", aluimm, 1);

        @(negedge clk);
        drive(6'h00, 6'b000010, 5'd1, 5'd5, 0, 1, 0, 5'd1, 0, 5'd0);
        #1;
        check("srl_wreg", wreg, 1);
        check("srl_shift", shift, 1);
        check("srl_regrt", regrt, 0);
        check("srl_aluc", aluc, 5'b00111);
        check("srl_a_depen", a_depen, 2'b01);
        check("srl_b_depen", b_depen, 2'b00);
        check("srl_load_depen", load_depen, 0);

        drive(6'h00, 6'h20, 5'd3, 5'd7, 0, 1, 1, 5'd3, 0, 5'd0);
        #1;
        check("lu_load_depen", load_depen, 1);
        check("lu_wreg", wreg, 0);
        check("lu_a_depen", a_depen, 2'b00);
        drive(6'h00, 6'h20, 5'd0, 5'd7, 0, 1, 1, 5'd0, 0, 5'd0);
        #1;
        check("lu_r0_load_depen", load_depen, 0);
        check("lu_r0_wreg", wreg, 1);

        drive(6'h04, 6'h00, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("beq_pcsource", pcsource, 2'b01);
        check("beq_sext", sext, 1);
        check("beq_aluc", aluc, 5'b00001);
        drive(6'h05, 6'h00, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("bne_pcsource", pcsource, 2'b00);
        drive(6'h00, 6'h08, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("jr_pcsource", pcsource, 2'b10);
        drive(6'h03, 6'h00, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("jal_pcsource", pcsource, 2'b11);
        check("jal_jal", jal, 1);
        check("jal_wreg", wreg, 1);

        drive(6'h00, 6'h20, 5'd4, 5'd0, 0, 1, 0, 5'd4, 1, 5'd4);
        #1;
        check("fwd_ex_prio", a_depen, 2'b01);
        drive(6'h00, 6'h20, 5'd4, 5'd0, 0, 0, 0, 5'd4, 1, 5'd0);
        #1;
        check("fwd_mem_r0", b_depen, 2'b00);
        drive(6'h00, 6'h20, 5'd4, 5'd0, 0, 0, 0, 5'd4, 1, 5'd4);
        #1;
        check("fwd_mem", a_depen, 2'b10);

        drive(6'h3F, 6'h20, 5'd4, 5'd5, 1, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("undef_op_ctrl", ctrl_vec(), 15'd0);
        drive(6'h00, 6'h3F, 5'd4, 5'd5, 1, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("undef_func_ctrl", ctrl_vec(), 15'd0);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            idx = $urandom_range(0, tbl.size() - 1);
            e = tbl[idx];
            op      = e.is_r ? 6'd0 : e.code;
            func    = e.is_r ? e.code : 6'($urandom);
            rs      = 5'($urandom_range(0, 7));
            rt      = 5'($urandom_range(0, 7));
            rsrtequ = 1'($urandom);
            ewreg   = 1'($urandom);
            em2reg  = 1'($urandom);
            ern     = 5'($urandom_range(0, 7));
            mwreg   = 1'($urandom);
            mrn     = 5'($urandom_range(0, 7));
            #1;
            model(e, 1'b1, ec, eh);
            check("rand_ctrl", ctrl_vec(), ec);
            check("rand_hazard", {load_depen, a_depen, b_depen}, eh);
        end

`ifdef PIPEIDCU_STALL_CNT_EN
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("cnt_reset", stall_cnt, 0);
        clrn = 1'b1;
        @(negedge clk);
        drive(6'h00, 6'h20, 5'd3, 5'd7, 0, 1, 1, 5'd3, 0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        drive(6'h00, 6'h20, 5'd3, 5'd7, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("cnt_three", stall_cnt, 3);
        clrn = 1'b0;
        #1;
        check("cnt_pulse_clear", stall_cnt, 0);
        clrn = 1'b1;
`endif

        @(negedge clk);
        drive(6'h00, 6'h20, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 5'd0);
        #1;
        check("pre_async_wreg", wreg, 1);
        clrn = 1'b0;
        #1;
        check("async_reset_wreg", wreg, 0);
        check("async_reset_aluc", aluc, 5'b00000);
        #3 clrn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
